// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags and
// sticky overflow/underflow errors. First-word-fall-through read port.
module fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] w_data,
  input  logic              pop,
  output logic [DATA_W-1:0] r_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AfCnt    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AeCnt    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = (ADDR_W)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              do_push, do_pop;

  // Flags come only from registered count, so they carry no input-to-output paths.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    r_data       = mem[r_ptr_q];
  end

  // A push while full is only accepted when a pop frees the head slot on the same edge.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);

    w_ptr_d = do_push ? w_ptr_q + PtrOne : w_ptr_q;
    r_ptr_d = do_pop  ? r_ptr_q + PtrOne : r_ptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // A fresh error event outranks a clear on the same edge.
    overflow_d  = (push & ~do_push) | (overflow_q & ~clr_err);
    underflow_d = (pop & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; contents are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[w_ptr_q] <= w_data;
    end
  end

endmodule
